// File: rtl/manchester_pkg.sv
// Shared constants and state encoding for the Manchester escape/unescape pair.
package manchester_pkg;
  localparam int          DATA_WIDTH_DEF = 8;
  localparam logic [7:0]  ESCAPE_SYMBOL  = 8'hE5;
  localparam logic [7:0]  ESCAPED_SYMBOL = 8'hD5;

  typedef enum logic {
    NORMAL = 1'b0,
    ESC    = 1'b1
  } unesc_state_t;
endpackage

// File: rtl/axis_out_reg.sv
// Single-stage AXIS register slice carrying tdata/tlast/tuser.
module axis_out_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  input  logic                  load_user,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] tdata,
  output logic                  tvalid,
  output logic                  tlast,
  output logic                  tuser,
  input  logic                  tready
);
  // Upstream may push whenever the slot is empty or being drained this cycle.
  assign ready = !tvalid || tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tvalid <= 1'b0;
      tdata  <= '0;
      tlast  <= 1'b0;
      tuser  <= 1'b0;
    end else if (load) begin
      tvalid <= 1'b1;
      tdata  <= load_data;
      tlast  <= load_last;
      tuser  <= load_user;
    end else if (tready) begin
      tvalid <= 1'b0;
    end
  end
endmodule

// File: rtl/manchester_unescape.sv
// Strips escape prefixes and start-of-frame delimiters from the received byte stream.
module manchester_unescape #(
  parameter int                    DATA_WIDTH     = manchester_pkg::DATA_WIDTH_DEF,
  parameter logic [DATA_WIDTH-1:0] ESCAPE_SYMBOL  = manchester_pkg::ESCAPE_SYMBOL,
  parameter logic [DATA_WIDTH-1:0] ESCAPED_SYMBOL = manchester_pkg::ESCAPED_SYMBOL,
  parameter int                    ERR_CNT_WIDTH  = 16
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic                     s_axis_tlast,
  output logic [DATA_WIDTH-1:0]    m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tuser,
  output logic                     err_pulse,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);
  import manchester_pkg::*;

  unesc_state_t state, state_n;
  logic         sof_pend, sof_n;
  logic         accept, emit, err;

  assign accept = s_axis_tvalid && s_axis_tready;

  always_comb begin
    state_n = state;
    sof_n   = sof_pend;
    emit    = 1'b0;
    err     = 1'b0;
    if (accept) begin
      case (state)
        NORMAL: begin
          if (s_axis_tdata == ESCAPE_SYMBOL) begin
            // An escape closing a frame has nothing to escape; drop it.
            if (s_axis_tlast) err = 1'b1;
            else              state_n = ESC;
          end else if (s_axis_tdata == ESCAPED_SYMBOL) begin
            sof_n = 1'b1;
            err   = s_axis_tlast;
          end else begin
            emit  = 1'b1;
            sof_n = 1'b0;
          end
        end
        ESC: begin
          emit    = 1'b1;
          sof_n   = 1'b0;
          state_n = NORMAL;
          err     = (s_axis_tdata != ESCAPE_SYMBOL) && (s_axis_tdata != ESCAPED_SYMBOL);
        end
        default: state_n = NORMAL;
      endcase
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state     <= NORMAL;
      sof_pend  <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_n;
      sof_pend  <= sof_n;
      err_pulse <= err;
      if (err && (err_count != '1)) err_count <= err_count + 1'b1;
    end
  end

  axis_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out (
    .clk       (aclk),
    .rst       (areset),
    .load      (emit),
    .load_data (s_axis_tdata),
    .load_last (s_axis_tlast),
    .load_user (sof_pend),
    .ready     (s_axis_tready),
    .tdata     (m_axis_tdata),
    .tvalid    (m_axis_tvalid),
    .tlast     (m_axis_tlast),
    .tuser     (m_axis_tuser),
    .tready    (m_axis_tready)
  );
endmodule

// File: tb/tb_manchester_unescape.sv
// Scoreboard bench for manchester_unescape: directed frames, backpressure, errors, reset.
module tb_manchester_unescape;
  logic        aclk = 0, areset = 1;
  logic [7:0]  s_tdata = 0;
  logic        s_tvalid = 0, s_tlast = 0, s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tlast, m_tuser, m_tready = 1;
  logic        err_pulse;
  logic [15:0] err_count;
  // Narrow-counter instance sharing the same stimulus, for saturation checks.
  logic        z_tready, z_tvalid, z_tlast, z_tuser, z_pulse;
  logic [7:0]  z_tdata;
  logic [2:0]  z_count;

  int checks = 0, errors = 0, pulses = 0;
  logic [9:0] exp_q[$];
  logic       bp_en = 0;
  logic [3:0] bp_pat = 4'b1001;   // bit0 first: 1,0,0,1
  int         bp_k = 0;
  logic       hold_v = 0;
  logic [9:0] held;

  always #5 aclk = ~aclk;

  manchester_unescape dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .err_pulse(err_pulse), .err_count(err_count)
  );

  manchester_unescape #(.ERR_CNT_WIDTH(3)) dut_sat (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(z_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(z_tdata), .m_axis_tvalid(z_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(z_tlast), .m_axis_tuser(z_tuser),
    .err_pulse(z_pulse), .err_count(z_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // expected output beat: {data, last, user}
  task automatic expect_beat(input logic [7:0] d, input logic l, input logic u);
    exp_q.push_back({d, l, u});
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    logic ok;
    int n;
    n = 0;
    s_tdata = d; s_tlast = l; s_tvalid = 1;
    do begin
      @(negedge aclk); ok = s_tready;
      @(posedge aclk); #1; n++;
    end while (!ok && n < 200);
    if (!ok) begin
      errors++; checks++;
      $display("FAIL send_timeout: byte %0h not accepted", d);
    end
  endtask

  task automatic drain();
    int n;
    s_tvalid = 0; s_tlast = 0;
    n = 0;
    while ((exp_q.size() != 0 || m_tvalid) && n < 200) begin
      @(posedge aclk); #1; n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL drain_timeout: %0d beats still expected", exp_q.size());
    end
    repeat (2) @(posedge aclk);
    #1;
  endtask

  always @(posedge aclk) begin
    #1;
    if (bp_en) begin
      m_tready = bp_pat[bp_k % 4];
      bp_k++;
    end
  end

  // Monitor: handshakes are stable from negedge through the next posedge.
  always @(negedge aclk) begin
    if (!areset) begin
      checks++;
      if (s_tready !== (!m_tvalid || m_tready)) begin
        errors++;
        $display("FAIL s_tready: got %0b with m_tvalid=%0b m_tready=%0b", s_tready, m_tvalid, m_tready);
      end
      if (hold_v && m_tvalid) begin
        checks++;
        if ({m_tdata, m_tlast, m_tuser} !== held) begin
          errors++;
          $display("FAIL stall_stable: got %0h expected %0h", {m_tdata, m_tlast, m_tuser}, held);
        end
      end
      hold_v = m_tvalid && !m_tready;
      held   = {m_tdata, m_tlast, m_tuser};
      if (m_tvalid && m_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got %0h expected none", {m_tdata, m_tlast, m_tuser});
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          if ({m_tdata, m_tlast, m_tuser} !== e) begin
            errors++;
            $display("FAIL out_beat: got data=%0h last=%0b user=%0b expected data=%0h last=%0b user=%0b",
                     m_tdata, m_tlast, m_tuser, e[9:2], e[1], e[0]);
          end
        end
      end
      if (err_pulse) pulses++;
    end
  end

  task automatic golden();
    expect_beat(8'hD5, 0, 0); expect_beat(8'h11, 0, 0); expect_beat(8'h22, 0, 0);
    expect_beat(8'h33, 0, 0); expect_beat(8'hE5, 1, 0); expect_beat(8'h44, 0, 0);
    send(8'hE5, 0); send(8'hD5, 0); send(8'h11, 0); send(8'h22, 0);
    send(8'h33, 0); send(8'hE5, 0); send(8'hE5, 1); send(8'h44, 0);
    drain();
  endtask

  initial begin
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_count", err_count, 0);
    areset = 0;
    @(posedge aclk); #1;

    golden();
    chk("golden_count", err_count, 0);
    chk("golden_pulses", pulses, 0);

    expect_beat(8'hAA, 0, 1); expect_beat(8'hBB, 1, 0);
    send(8'hD5, 0); send(8'hAA, 0); send(8'hBB, 1);
    drain();
    expect_beat(8'hCC, 0, 1);
    send(8'hD5, 0); send(8'hD5, 0); send(8'hCC, 0);
    drain();
    chk("sof_count", err_count, 0);

    bp_en = 1; bp_k = 0;
    golden();
    bp_en = 0; m_tready = 1;
    chk("bp_count", err_count, 0);

    expect_beat(8'h7F, 0, 0);
    send(8'hE5, 0); send(8'h7F, 0);
    drain();
    chk("badesc_count", err_count, 1);
    chk("badesc_pulses", pulses, 1);

    send(8'hE5, 1);
    drain();
    chk("dangling_count", err_count, 2);
    chk("dangling_pulses", pulses, 2);

    expect_beat(8'h55, 0, 1);
    send(8'hD5, 1); send(8'h55, 0);
    drain();
    chk("sof_last_count", err_count, 3);

    send(8'hE5, 1); send(8'hE5, 1);
    drain();
    chk("b2b_count", err_count, 5);
    chk("b2b_pulses", pulses, 5);
    chk("sat_below", z_count, 5);

    for (int i = 0; i < 4; i++) send(8'hE5, 1);
    drain();
    chk("many_count", err_count, 9);
    chk("sat_hold", z_count, 7);

    send(8'hE5, 0);
    s_tvalid = 0;
    areset = 1;
    @(negedge aclk);
    chk("rstmid_tvalid", m_tvalid, 0);
    chk("rstmid_tdata", m_tdata, 0);
    chk("rstmid_tlast", m_tlast, 0);
    chk("rstmid_tuser", m_tuser, 0);
    chk("rstmid_pulse", err_pulse, 0);
    chk("rstmid_count", err_count, 0);
    exp_q.delete();
    @(posedge aclk); #1;
    areset = 0;
    @(posedge aclk); #1;
    expect_beat(8'h12, 0, 1);
    send(8'hD5, 0); send(8'h12, 0);
    drain();
    chk("post_rst_count", err_count, 0);
    chk("leftover", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
